// File: rtl/fifo_async_circular.sv
// Single-clock circular-buffer FIFO with wrap-bit pointers and registered read data.
// Optional sticky overflow/underflow outputs when FIFO_ASYNC_CIRCULAR_ERR_FLAGS_EN is defined.
module fifo_async_circular #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             write_in,
  input  logic [WIDTH-1:0] data_write_in,
  input  logic             read_in,
  output logic [WIDTH-1:0] data_read_out,
  output logic             full_out,
  output logic             empty_out,
`ifdef FIFO_ASYNC_CIRCULAR_ERR_FLAGS_EN
  output logic             overflow_out,
  output logic             underflow_out,
`endif
  output logic [AW:0]      level_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_en, rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty_out = (wr_ptr_q == rd_ptr_q);
    full_out  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    level_out = wr_ptr_q - rd_ptr_q;
    wr_en     = write_in && !full_out;
    rd_en     = read_in && !empty_out;
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, rd_en};
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is never cleared; reset only discards it by rewinding the pointers.
  always_ff @(posedge clk) begin
    if (!rst_in && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_write_in;
  end

  assign data_read_out = rd_data_q;

`ifdef FIFO_ASYNC_CIRCULAR_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (write_in & full_out);
    unf_d = unf_q | (read_in & empty_out);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;
`endif

endmodule

// File: tb/tb_fifo_async_circular.sv
// Bench for fifo_async_circular: directed vector table, corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_fifo_async_circular;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_in = 1'b0;
  logic             write_in = 1'b0;
  logic [WIDTH-1:0] data_write_in = '0;
  logic             read_in = 1'b0;
  logic [WIDTH-1:0] data_read_out;
  logic             full_out, empty_out;
  logic [AW:0]      level_out;
`ifdef FIFO_ASYNC_CIRCULAR_ERR_FLAGS_EN
  logic             overflow_out, underflow_out;
`endif

  fifo_async_circular #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_in(rst_in), .write_in(write_in), .data_write_in(data_write_in),
    .read_in(read_in), .data_read_out(data_read_out), .full_out(full_out),
    .empty_out(empty_out),
`ifdef FIFO_ASYNC_CIRCULAR_ERR_FLAGS_EN
    .overflow_out(overflow_out), .underflow_out(underflow_out),
`endif
    .level_out(level_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [WIDTH-1:0] q_m[$];
  logic [WIDTH-1:0] dout_m = '0;
  bit               ovf_m = 1'b0, unf_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, update the model, check after the rising edge.
  task automatic step(input bit rst, input bit wr, input bit rd, input logic [WIDTH-1:0] din);
    bit full_b, empty_b;
    @(negedge clk);
    rst_in = rst; write_in = wr; read_in = rd; data_write_in = din;
    full_b  = (q_m.size() == DEPTH);
    empty_b = (q_m.size() == 0);
    @(posedge clk);
    #1;
    if (rst) begin
      q_m.delete();
      dout_m = '0;
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (wr && full_b) ovf_m = 1'b1;
      if (rd && empty_b) unf_m = 1'b1;
      if (rd && !empty_b) dout_m = q_m.pop_front();
      if (wr && !full_b) q_m.push_back(din);
    end
    chk("model_dout",  32'(data_read_out), 32'(dout_m));
    chk("model_level", 32'(level_out),     32'(q_m.size()));
    chk("model_full",  32'(full_out),      32'(q_m.size() == DEPTH));
    chk("model_empty", 32'(empty_out),     32'(q_m.size() == 0));
`ifdef FIFO_ASYNC_CIRCULAR_ERR_FLAGS_EN
    chk("model_ovf", 32'(overflow_out),  32'(ovf_m));
    chk("model_unf", 32'(underflow_out), 32'(unf_m));
`endif
  endtask

  typedef struct {
    bit               rst, wr, rd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_dout;
    bit               exp_full, exp_empty;
    int               exp_level;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1, 0, 0, 8'h00, 8'h00, 0, 1, 0};  // reset
    vecs[1]  = '{0, 1, 0, 8'h10, 8'h00, 0, 0, 1};
    vecs[2]  = '{0, 1, 0, 8'h01, 8'h00, 0, 0, 2};
    vecs[3]  = '{0, 1, 0, 8'h91, 8'h00, 0, 0, 3};
    vecs[4]  = '{0, 0, 1, 8'h00, 8'h10, 0, 0, 2};
    vecs[5]  = '{0, 0, 1, 8'h00, 8'h01, 0, 0, 1};
    vecs[6]  = '{0, 0, 1, 8'h00, 8'h91, 0, 1, 0};
    vecs[7]  = '{0, 0, 1, 8'h00, 8'h91, 0, 1, 0};  // read while empty: ignored
    vecs[8]  = '{0, 1, 1, 8'hAA, 8'h91, 0, 0, 1};  // both on empty: write only
    vecs[9]  = '{0, 0, 1, 8'h00, 8'hAA, 0, 1, 0};
    vecs[10] = '{1, 1, 1, 8'h55, 8'h00, 0, 1, 0};  // reset beats read/write

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("vec%0d_dout", i),  32'(data_read_out), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_full", i),  32'(full_out),      32'(vecs[i].exp_full));
      chk($sformatf("vec%0d_empty", i), 32'(empty_out),     32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_level", i), 32'(level_out),     32'(vecs[i].exp_level));
    end

    // Overfill: 32 writes, only the first 16 stored
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 0, 8'(8'h30 + i));
      if (i == 15) chk("fill16_full", 32'(full_out), 32'd1);
    end
    chk("overfill_level", 32'(level_out), 32'd16);
`ifdef FIFO_ASYNC_CIRCULAR_ERR_FLAGS_EN
    chk("overfill_ovf", 32'(overflow_out), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 8'h00);
      chk("drain_order", 32'(data_read_out), 32'(8'h30 + i));
    end
    chk("drain_empty", 32'(empty_out), 32'd1);

    // Wrap-around: 12 in, 8 out, 10 in, 14 out
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 8'(8'hC0 + i));
    chk("wrap_lvl12", 32'(level_out), 32'd12);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00);
    chk("wrap_lvl4", 32'(level_out), 32'd4);
    chk("wrap_dout8", 32'(data_read_out), 32'(8'hC7));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'(8'hE0 + i));
    chk("wrap_lvl14", 32'(level_out), 32'd14);
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 1, 8'h00);
      chk("wrap_order", 32'(data_read_out), (i < 4) ? 32'(8'hC8 + i) : 32'(8'hE0 + i - 4));
    end
    chk("wrap_lvl0", 32'(level_out), 32'd0);

    // Simultaneous read+write on full, then on empty
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h70 + i));
    chk("both_full_pre", 32'(full_out), 32'd1);
    step(0, 1, 1, 8'hFF);
    chk("both_full_lvl", 32'(level_out), 32'd15);
    chk("both_full_dout", 32'(data_read_out), 32'(8'h70));
    for (int i = 0; i < 15; i++) step(0, 0, 1, 8'h00);
    chk("both_drained_dout", 32'(data_read_out), 32'(8'h7F));
    step(0, 1, 1, 8'h3C);
    chk("both_empty_lvl", 32'(level_out), 32'd1);
    chk("both_empty_dout", 32'(data_read_out), 32'(8'h7F));

    // Reset with 5 stored words, then a read on the emptied FIFO
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h20 + i));
    step(1, 0, 0, 8'h00);
    chk("rst5_empty", 32'(empty_out), 32'd1);
    step(0, 0, 1, 8'h00);
    chk("rst5_dout", 32'(data_read_out), 32'd0);
`ifdef FIFO_ASYNC_CIRCULAR_ERR_FLAGS_EN
    chk("rst5_unf", 32'(underflow_out), 32'd1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
